// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and the
// device acknowledge code used by the receiver side.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    ACK_WAIT
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_CMD_DEFAULTS = 8'hF6;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Bit index of the stop bit inside the host-to-device frame.
  localparam logic [3:0] PS2_STOP_IDX     = 4'd9;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_command_tx_if.sv
// Command handshake between the control path and the PS/2 transmitter.
interface ps2_command_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus falling-edge
// detect on the synchronized clock; shared with the PS/2 receiver.
module ps2_line_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_pipe_q, clk_pipe_d;
  logic [1:0] dat_pipe_q, dat_pipe_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_pipe_d = {clk_pipe_q[0], clk_in};
    dat_pipe_d = {dat_pipe_q[0], dat_in};
    clk_prev_d = clk_pipe_q[1];
  end

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_pipe_q <= '1;
      dat_pipe_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_pipe_q <= clk_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clk_sync = clk_pipe_q[1];
  assign dat_sync = dat_pipe_q[1];
  assign clk_fall = clk_prev_q & ~clk_pipe_q[1];

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clk/dat enables.
// Optional macro PS2_TX_RETRY_EN: retry NACK/timeout up to twice before error.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  ps2_command_tx_if.slave  cmd,
  input  logic             ps2_clk_in,
  input  logic             ps2_dat_in,
  output logic             ps2_clk_oe,
  output logic             ps2_dat_oe,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic clk_sync, dat_sync, clk_fall;
  logic attempt_failed;
  logic bit_val;
  logic ready;

  ps2_line_sync u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    parity_d       = parity_q;
    ack_d          = ack_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    attempt_failed = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d        = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_d  = INHIBIT;
          cnt_d    = '0;
          shift_d  = cmd.cmd_data;
          parity_d = ps2_odd_parity(cmd.cmd_data);
`ifdef PS2_TX_RETRY_EN
          retry_d  = '0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d = RTS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RTS, DATA, ACK_WAIT: begin
        // One budget spans the whole device-clocked phase; falls never reload it.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TIMEOUT_LAST) begin
          attempt_failed = 1'b1;
        end else if (state_q == RTS) begin
          if (clk_fall) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else if (state_q == DATA) begin
          if (clk_fall) begin
            if (idx_q == PS2_STOP_IDX) begin
              state_d = ACK_WAIT;
              ack_d   = ~dat_sync;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end else if (clk_sync && dat_sync) begin
          if (ack_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            attempt_failed = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (attempt_failed) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d = retry_q + 2'd1;
        state_d = INHIBIT;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        error_d = 1'b1;
      end
`else
      state_d = IDLE;
      error_d = 1'b1;
`endif
    end
  end

  always_comb begin
    ready      = 1'b0;
    busy       = 1'b1;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    if (idx_q < 4'd8)       bit_val = shift_q[idx_q[2:0]];
    else if (idx_q == 4'd8) bit_val = parity_q;
    else                    bit_val = 1'b1;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      INHIBIT: ps2_clk_oe = 1'b1;
      RTS:     ps2_dat_oe = 1'b1;
      DATA:    ps2_dat_oe = ~bit_val;
      default: ;
    endcase
  end

  assign cmd.cmd_ready = ready;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx: a PS/2 device model clocks frames out of
// the transmitter and answers with ACK, NACK or silence.
module tb_ps2_command_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 5000;
  localparam int unsigned TMO = 2000;
  localparam int unsigned H   = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int NACK_ATTEMPTS = 3;
`else
  localparam int NACK_ATTEMPTS = 1;
`endif

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    logic [9:0] frame;
    int         exp_done;
    int         exp_error;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic line_clk, line_dat;
  logic clk_oe, dat_oe, busy, done, error;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int inh_cnt  = 0;
  logic clk_oe_prev = 1'b0;

  ps2_command_tx_if cmd_if ();

  assign line_clk = dev_clk & ~clk_oe;
  assign line_dat = dev_dat & ~dat_oe;

  ps2_command_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (20)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd        (cmd_if.slave),
    .ps2_clk_in (line_clk),
    .ps2_dat_in (line_dat),
    .ps2_clk_oe (clk_oe),
    .ps2_dat_oe (dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #10 clock = ~clock;

  always @(negedge clock) begin
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (clk_oe && !clk_oe_prev) inh_cnt++;
    clk_oe_prev = clk_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b);
    cmd_if.cmd_data  = b;
    cmd_if.cmd_valid = 1'b1;
    step(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // One transmit attempt as seen by the device; called on a negedge.
  task automatic run_frame(input bit ack, input logic [9:0] exp_frame, input string tag);
    int n;
    int len;
    logic [9:0] got;
    n = 0;
    while (!clk_oe && n < 200) begin step(1); n++; end
    len = 0;
    while (clk_oe && len < int'(INH) + 100) begin len++; step(1); end
    check({tag, "_inhibit_len"}, len, INH);
    check({tag, "_start_bit"}, {30'd0, line_clk, line_dat}, 32'h2);
    step(10);
    got = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && ack) begin dev_dat = 1'b0; step(5); end
      dev_clk = 1'b0;
      step(H);
      if (i < 10) got[i] = line_dat;
      dev_clk = 1'b1;
      if (i < 10) step(H);
    end
    check({tag, "_frame"}, {22'd0, got}, {22'd0, exp_frame});
    if (ack) begin step(H); dev_dat = 1'b1; end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (!cmd_if.cmd_ready && n < bound) begin step(1); n++; end
    check({tag, "_ready"}, cmd_if.cmd_ready, 1);
    check({tag, "_pulse_with_ready"}, done | error, 1);
  endtask

  initial begin
    vec_t vecs [5];
    int d0, e0, i0, n, len, attempts;

    vecs[0] = '{PS2_CMD_ENABLE,   1'b1, 10'h2F4, 1, 0};
    vecs[1] = '{PS2_CMD_RESET,    1'b0, 10'h3FF, 0, 1};
    vecs[2] = '{PS2_CMD_SET_RATE, 1'b1, 10'h3F3, 1, 0};
    vecs[3] = '{PS2_CMD_DEFAULTS, 1'b1, 10'h3F6, 1, 0};
    vecs[4] = '{8'h00,            1'b1, 10'h300, 1, 0};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = 8'h00;
    step(3);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_oe",    {30'd0, clk_oe, dat_oe}, 0);
    check("rst_pulse", {30'd0, done, error}, 0);
    reset_n = 1'b1;
    step(2);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
      send(vecs[v].cmd);
      attempts = vecs[v].ack ? 1 : NACK_ATTEMPTS;
      for (int a = 0; a < attempts; a++)
        run_frame(vecs[v].ack, vecs[v].frame, $sformatf("vec%0d", v));
      wait_idle($sformatf("vec%0d", v), 500);
      step(2);
      check($sformatf("vec%0d_done", v),  done_cnt - d0, vecs[v].exp_done);
      check($sformatf("vec%0d_error", v), err_cnt - e0,  vecs[v].exp_error);
      check($sformatf("vec%0d_inhibits", v), inh_cnt - i0, attempts);
      check($sformatf("vec%0d_lines", v), {30'd0, clk_oe, dat_oe}, 0);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Device never clocks: RTS lasts exactly the timeout budget.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    send(PS2_CMD_ENABLE);
    n = 0;
    while (clk_oe && n < int'(INH) + 100) begin step(1); n++; end
    len = 0;
    while (dat_oe && len < int'(TMO) + 100) begin len++; step(1); end
    check("tmo_rts_len", len, TMO);
    wait_idle("tmo", NACK_ATTEMPTS * int'(INH + TMO) + 100);
    step(2);
    check("tmo_error", err_cnt - e0, 1);
    check("tmo_done", done_cnt - d0, 0);
    check("tmo_inhibits", inh_cnt - i0, NACK_ATTEMPTS);
    check("tmo_lines", {30'd0, clk_oe, dat_oe}, 0);

    // cmd_valid held with cmd_data changing after accept.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    cmd_if.cmd_data  = PS2_CMD_ENABLE;
    cmd_if.cmd_valid = 1'b1;
    step(1);
    cmd_if.cmd_data = PS2_CMD_DEFAULTS;
    run_frame(1'b1, 10'h2F4, "held1");
    wait_idle("held1", 500);
    step(1);
    cmd_if.cmd_valid = 1'b0;
    run_frame(1'b1, 10'h3F6, "held2");
    wait_idle("held2", 500);
    step(2);
    check("held_done", done_cnt - d0, 2);
    check("held_error", err_cnt - e0, 0);
    check("held_inhibits", inh_cnt - i0, 2);

    // Reset while the bit at idx 4 is presented.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    send(PS2_CMD_ENABLE);
    n = 0;
    while (clk_oe && n < int'(INH) + 100) begin step(1); n++; end
    step(10);
    for (int i = 0; i < 5; i++) begin
      dev_clk = 1'b0;
      step(H);
      if (i < 4) begin dev_clk = 1'b1; step(H); end
    end
    check("rstmid_busy_before", busy, 1);
    reset_n = 1'b0;
    step(1);
    check("rstmid_busy", busy, 0);
    check("rstmid_lines", {30'd0, clk_oe, dat_oe}, 0);
    check("rstmid_ready", cmd_if.cmd_ready, 1);
    reset_n = 1'b1;
    dev_clk = 1'b1;
    step(20);
    check("rstmid_done", done_cnt - d0, 0);
    check("rstmid_error", err_cnt - e0, 0);
    check("rstmid_idle", busy, 0);

`ifdef PS2_TX_RETRY_EN
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    send(PS2_CMD_ENABLE);
    run_frame(1'b0, 10'h2F4, "retry1");
    run_frame(1'b0, 10'h2F4, "retry2");
    run_frame(1'b1, 10'h2F4, "retry3");
    wait_idle("retry", 500);
    step(2);
    check("retry_done", done_cnt - d0, 1);
    check("retry_error", err_cnt - e0, 0);
    check("retry_inhibits", inh_cnt - i0, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
